// File: rtl/alu_parity_pipe.sv
// alu_parity_pipe: 3-stage one-hot ALU (decode, ALU, parity/output).
// Define ALU_PARITY_PIPE_ERRCNT_EN to enable the saturating err_count.
module alu_parity_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       funccode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             parity,
  output logic             op_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       err_count
);

  logic             s1_v_q;
  logic [2:0]       s1_op_q;
  logic             s1_err_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_d;
  logic             s1_err_d;

  logic             s2_v_q;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_err_q;
  logic [WIDTH-1:0] s2_res_d;
  logic [WIDTH-1:0] alu;

  logic             s3_v_q;
  logic [WIDTH-1:0] s3_res_q;
  logic             s3_par_q;
  logic             s3_err_q;

  logic             s2_adv;
  logic             s3_adv;

  // Stage advance chain: a stage moves when empty or its successor moves
  always_comb begin
    s3_adv   = !s3_v_q || out_ready;
    s2_adv   = !s2_v_q || s3_adv;
    in_ready = !s1_v_q || s2_adv;
  end

  // One-hot to binary opcode; flag zero or multi-hot selects
  always_comb begin
    s1_op_d = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (funccode[i]) s1_op_d = 3'(i);
    end
    s1_err_d = (funccode == 8'd0) ||
               ((funccode & (funccode - 8'd1)) != 8'd0);
  end

  // S1: capture decoded op and operands
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_op_q  <= '0;
      s1_err_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else if (in_ready) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_op_q  <= s1_op_d;
        s1_err_q <= s1_err_d;
        s1_a_q   <= a;
        s1_b_q   <= b;
      end
    end
  end

  // ALU; an illegal select forces a zero result
  always_comb begin
    alu = '0;
    unique case (s1_op_q)
      3'd0: alu = s1_a_q + s1_b_q;
      3'd1: alu = s1_a_q - s1_b_q;
      3'd2: alu = s1_a_q & s1_b_q;
      3'd3: alu = s1_a_q | s1_b_q;
      3'd4: alu = s1_a_q ^ s1_b_q;
      3'd5: alu = ~s1_a_q;
      3'd6: alu = {s1_a_q[WIDTH-2:0], 1'b0};
      3'd7: alu = {1'b0, s1_a_q[WIDTH-1:1]};
    endcase
    s2_res_d = s1_err_q ? '0 : alu;
  end

  // S2: register ALU result and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q   <= 1'b0;
      s2_res_q <= '0;
      s2_err_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_res_q <= s2_res_d;
        s2_err_q <= s1_err_q;
      end
    end
  end

  // S3: output register with parity of the result
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v_q   <= 1'b0;
      s3_res_q <= '0;
      s3_par_q <= 1'b0;
      s3_err_q <= 1'b0;
    end else if (s3_adv) begin
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        s3_res_q <= s2_res_q;
        s3_par_q <= ^s2_res_q;
        s3_err_q <= s2_err_q;
      end
    end
  end

  assign result    = s3_res_q;
  assign parity    = s3_par_q;
  assign op_err    = s3_err_q;
  assign out_valid = s3_v_q;

`ifdef ALU_PARITY_PIPE_ERRCNT_EN
  logic [7:0] errcnt_q;
  logic [7:0] errcnt_d;

  // Count erroneous output transfers, saturating at 255
  always_comb begin
    errcnt_d = errcnt_q;
    if (s3_v_q && out_ready && s3_err_q && (errcnt_q != 8'hFF))
      errcnt_d = errcnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) errcnt_q <= 8'd0;
    else     errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_parity_pipe.sv
// tb_alu_parity_pipe: scoreboard bench for alu_parity_pipe.
// Covers WIDTH=4 and WIDTH=8 instances sharing clk/rst.
module tb_alu_parity_pipe;

`ifdef ALU_PARITY_PIPE_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] res;
    logic       par;
    logic       err;
    int         edg;
    bit         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] fc4, fc8;
  logic [3:0] a4, b4, res4;
  logic [7:0] a8, b8, res8;
  logic       iv4, ir4, par4, err4, ov4, or4;
  logic       iv8, ir8, par8, err8, ov8, or8;
  logic [7:0] ec4, ec8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   cyc = 0;
  int   nchk = 0;
  int   npass = 0;
  int   nacc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_parity_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .funccode(fc4), .a(a4), .b(b4),
    .in_valid(iv4), .in_ready(ir4), .result(res4),
    .parity(par4), .op_err(err4), .out_valid(ov4),
    .out_ready(or4), .err_count(ec4)
  );

  alu_parity_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .funccode(fc8), .a(a8), .b(b8),
    .in_valid(iv8), .in_ready(ir8), .result(res8),
    .parity(par8), .op_err(err8), .out_valid(ov8),
    .out_ready(or8), .err_count(ec8)
  );

  function automatic void chk(string nm, int act, int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nm, act, exp, $time);
  endfunction

  // Output monitors: compare every output transfer against the queue
  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      if (q4.size() == 0) begin
        chk("w4_unexpected_out_valid", int'(ov4), 0);
      end else begin
        e4 = q4.pop_front();
        chk("w4_result", int'(res4), int'(e4.res[3:0]));
        chk("w4_parity", int'(par4), int'(e4.par));
        chk("w4_op_err", int'(err4), int'(e4.err));
        if (e4.lat) chk("w4_latency", cyc + 1 - e4.edg, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_out_valid", int'(ov8), 0);
      end else begin
        e8 = q8.pop_front();
        chk("w8_result", int'(res8), int'(e8.res));
        chk("w8_parity", int'(par8), int'(e8.par));
        chk("w8_op_err", int'(err8), int'(e8.err));
      end
    end
  end

  // Issue one transaction; push its expectation when accepted
  task automatic send(input bit w8, input logic [7:0] f,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] er, input logic ep,
                      input logic ee, input bit lat);
    int   n;
    exp_t x;
    n = 0;
    if (w8) begin
      fc8 = f; a8 = av; b8 = bv; iv8 = 1'b1;
    end else begin
      fc4 = f; a4 = av[3:0]; b4 = bv[3:0]; iv4 = 1'b1;
    end
    @(negedge clk);
    while (!(w8 ? ir8 : ir4) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      chk("send_timeout", n, 0);
    end else begin
      x.res = er; x.par = ep; x.err = ee;
      x.edg = cyc + 1; x.lat = lat;
      if (w8) q8.push_back(x);
      else    q4.push_back(x);
      nacc++;
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
    iv8 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk);
    while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain_q4", q4.size(), 0);
    chk("drain_q8", q8.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv4 = 1'b0; iv8 = 1'b0;
    fc4 = 8'h0; a4 = 4'h0; b4 = 4'h0;
    fc8 = 8'h0; a8 = 8'h0; b8 = 8'h0;
    or4 = 1'b1; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", int'(ov4), 0);
    chk("rst_result",    int'(res4), 0);
    chk("rst_parity",    int'(par4), 0);
    chk("rst_op_err",    int'(err4), 0);
    chk("rst_err_count", int'(ec4), 0);
    chk("rst_in_ready",  int'(ir4), 1);

    // Eight one-hot ops, a=1 b=1, back to back
    send(0, 8'h01, 8'h1, 8'h1, 8'h2, 1, 0, 1);
    send(0, 8'h02, 8'h1, 8'h1, 8'h0, 0, 0, 1);
    send(0, 8'h04, 8'h1, 8'h1, 8'h1, 1, 0, 1);
    send(0, 8'h08, 8'h1, 8'h1, 8'h1, 1, 0, 1);
    send(0, 8'h10, 8'h1, 8'h1, 8'h0, 0, 0, 1);
    send(0, 8'h20, 8'h1, 8'h1, 8'hE, 1, 0, 1);
    send(0, 8'h40, 8'h1, 8'h1, 8'h2, 1, 0, 1);
    send(0, 8'h80, 8'h1, 8'h1, 8'h0, 0, 0, 1);

    // Wrap-around ADD / SUB
    send(0, 8'h01, 8'h5, 8'hA, 8'hF, 0, 0, 1);
    send(0, 8'h02, 8'h5, 8'hA, 8'hB, 1, 0, 1);

    // Illegal selects
    send(0, 8'h00, 8'h5, 8'h3, 8'h0, 0, 1, 1);
    send(0, 8'h03, 8'h5, 8'h3, 8'h0, 0, 1, 1);
    drain();
    chk("err_count_2", int'(ec4), ERR_EN ? 2 : 0);

    // Backpressure: five sends, output blocked 4 cycles
    or4 = 1'b0;
    nacc = 0;
    fork
      begin
        send(0, 8'h01, 8'h1, 8'h1, 8'h2, 1, 0, 0);
        send(0, 8'h01, 8'h2, 8'h1, 8'h3, 0, 0, 0);
        send(0, 8'h01, 8'h3, 8'h1, 8'h4, 1, 0, 0);
        send(0, 8'h01, 8'h4, 8'h1, 8'h5, 0, 0, 0);
        send(0, 8'h01, 8'h5, 8'h1, 8'h6, 0, 0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("stall_in_ready", int'(ir4), 0);
        chk("stall_accepts", nacc, 3);
        chk("stall_out_valid", int'(ov4), 1);
        or4 = 1'b1;
      end
    join
    drain();
    chk("stall_total", nacc, 5);

    // Counter saturation
    for (int i = 0; i < 260; i++)
      send(0, 8'h00, 8'h0, 8'h0, 8'h0, 0, 1, 0);
    drain();
    chk("err_count_sat", int'(ec4), ERR_EN ? 255 : 0);

    // Reset with three transactions in flight
    or4 = 1'b0;
    send(0, 8'h01, 8'h1, 8'h2, 8'h3, 0, 0, 0);
    send(0, 8'h04, 8'hF, 8'h7, 8'h7, 1, 0, 0);
    send(0, 8'h10, 8'h3, 8'h5, 8'h6, 0, 0, 0);
    rst = 1'b1;
    q4.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    or4 = 1'b1;
    chk("mid_rst_in_ready", int'(ir4), 1);
    chk("mid_rst_out_valid", int'(ov4), 0);
    chk("mid_rst_err_count", int'(ec4), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_quiet", int'(ov4), 0);

    // Input presented during reset is ignored
    rst = 1'b1;
    fc4 = 8'h01; a4 = 4'h1; b4 = 4'h1; iv4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iv4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_input_ignored", int'(ov4), 0);

    // WIDTH=8 wrap and shift boundaries
    send(1, 8'h01, 8'hFF, 8'h01, 8'h00, 0, 0, 0);
    send(1, 8'h40, 8'h80, 8'h00, 8'h00, 0, 0, 0);
    send(1, 8'h80, 8'h81, 8'h00, 8'h40, 1, 0, 0);
    send(1, 8'h02, 8'h00, 8'h01, 8'hFF, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/alu_parity_pipe.md
ALU_PARITY_PIPE -- requirements
Module: alu_parity_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset sampled on the clk rising edge.
REQ-004 The block SHALL have port funccode, input, 8 bits, the one-hot operation select.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-006 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), forming the upstream handshake.
REQ-007 The block SHALL have port result, output, WIDTH bits, the ALU result.
REQ-008 The block SHALL have port parity, output, 1 bit, the XOR-reduction of result.
REQ-009 The block SHALL have port op_err, output, 1 bit, set when funccode was not one-hot.
REQ-010 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), forming the downstream handshake.
REQ-011 The block SHALL have port err_count, output, 8 bits, the count of erroneous transactions.

Function
REQ-012 A transfer SHALL occur on an edge where valid and ready are both 1; the data SHALL be held stable while valid=1 and ready=0.
REQ-013 The pipeline SHALL have three registered stages: S1 decode (one-hot to 3-bit opcode, operands registered), S2 ALU, S3 parity/output.
REQ-014 Latency SHALL be exactly 3 cycles from the input transfer edge to out_valid=1 when out_ready is held at 1.
REQ-015 Throughput SHALL be one transaction per cycle when there is no backpressure.
REQ-016 Each stage SHALL advance when it is empty or when its downstream stage advances; in_ready SHALL equal (!S1_valid || S1 advances), combinationally.
REQ-017 When out_ready=0 with all stages full, the pipeline SHALL stall with no loss or duplication, and in_ready SHALL be 0.
REQ-018 Bubbles SHALL collapse: an empty stage SHALL accept data even while a later stage is stalled.
REQ-019 Opcodes SHALL be decoded as funccode bit i to op i: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 a<<1, 7 a>>1 (logical).
REQ-020 ADD and SUB SHALL wrap modulo 2^WIDTH; the carry and borrow SHALL be discarded.
REQ-021 For a funccode that is zero or has more than one bit set, op_err SHALL be 1 with that transaction, and result SHALL be 0 (parity 0).
REQ-022 The parity output SHALL be 1 exactly when result has an odd number of 1s.
REQ-023 The op_err and parity outputs SHALL travel with their transaction and be valid only when out_valid=1.

Reset
REQ-024 When rst=1 at an edge, all stage valid bits SHALL clear, and result, parity, op_err, out_valid and err_count SHALL be 0.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 A reset mid-operation SHALL discard every in-flight transaction; no out_valid SHALL appear for those transactions.
REQ-027 An input presented while rst=1 SHALL NOT be accepted.

Configuration
REQ-028 With macro ALU_PARITY_PIPE_ERRCNT_EN defined, err_count SHALL increment by 1 on each output transfer with op_err=1, and SHALL saturate at 255.
REQ-029 Without ALU_PARITY_PIPE_ERRCNT_EN, err_count SHALL be tied to 0 and no counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=4, out_ready=1, a=0001, b=0001, the eight one-hot funccodes issued back-to-back: outputs SHALL appear on consecutive cycles starting 3 cycles after the first transfer, with results 0010, 0000, 0001, 0001, 0000, 1110, 0010, 0000 and parity 1,0,1,1,0,1,1,0.
REQ-031 WIDTH=4, a=0101, b=1010, ADD then SUB: results SHALL be 1111 (parity 0), then 1011 (parity 1, borrow dropped).
REQ-032 funccode=00000000 and then 00000011: each SHALL give op_err=1, result=0 and parity=0; err_count SHALL be 2 with the macro defined and 0 without it.
REQ-033 Five transactions with out_ready=0 for 4 cycles: in_ready SHALL fall after 3 accepts; after out_ready rises, all 5 SHALL emerge in order, with none lost or duplicated.
REQ-034 rst pulsed for 1 cycle with 3 transactions in flight: no out_valid SHALL follow, and in_ready SHALL be 1 the next cycle.
REQ-035 WIDTH=8, a=0xFF, b=0x01, ADD: result SHALL be 0x00 with parity 0; a=0x80 with SHL SHALL give 0x00.
